datapath_arbiter: RTL and testbench

- Shares the single FIR datapath (register file plus ALU/MAC, driven by op/src1/src2/dest) between two requesters.
- Requester 0 is the sample/FIR sequencing controller; requester 1 is a host/debug register-access sequencer.
- Grants whole bursts of datapath ops, round-robin, with burst locking, overflow attribution and a watchdog that forces release of a stuck grant.
- Sits between the requesters' op buses and the datapath op port.

---
 rtl/datapath_pkg.sv | 23 ++
 rtl/datapath_arbiter_if.sv | 35 +++
 rtl/datapath_arbiter_grant_timer.sv | 27 ++
 rtl/datapath_arbiter.sv | 147 ++++++++++++++
 tb/tb_datapath_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the FIR datapath arbiter: op encodings, arbiter states, requester indices.
package datapath_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_COPY  = 3'b001,
        OP_LOAD1 = 3'b010,
        OP_LOAD2 = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_MUL   = 3'b110
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

endpackage

// File: rtl/datapath_arbiter_if.sv
// Requester and datapath-side signals of the arbiter; slave is the arbiter, master the surrounding logic.
interface datapath_arbiter_if;

    logic [1:0] req;
    logic [1:0] last;
    logic [2:0] op0;
    logic [3:0] src1_0;
    logic [3:0] src2_0;
    logic [3:0] dest0;
    logic [2:0] op1;
    logic [3:0] src1_1;
    logic [3:0] src2_1;
    logic [3:0] dest1;
    logic       overflow;
    logic [1:0] gnt;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       busy;
    logic [1:0] ovf_err;
    logic [1:0] abort;
    logic       timeout_err;

    modport slave (
        input  req, last, op0, src1_0, src2_0, dest0, op1, src1_1, src2_1, dest1, overflow,
        output gnt, op, src1, src2, dest, busy, ovf_err, abort, timeout_err
    );

    modport master (
        output req, last, op0, src1_0, src2_0, dest0, op1, src1_1, src2_1, dest1, overflow,
        input  gnt, op, src1, src2, dest, busy, ovf_err, abort, timeout_err
    );

endinterface

// File: rtl/datapath_arbiter_grant_timer.sv
// Grant-age counter: cleared at grant start, counts granted cycles, flags the last permitted cycle.
module grant_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] age;

    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else if (clr) begin
            age <= '0;
        end else if (en) begin
            age <= age + CNT_W'(1);
        end
    end

    assign expired = (age == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/datapath_arbiter.sv
// Burst-granting arbiter sharing the FIR datapath between two requesters.
// Build option FIXED_PRIORITY_EN: requester 0 always wins contention in IDLE (no RR pointer).
//
// state | meaning
// IDLE  | no grant, NOP on the datapath
// G0    | requester 0 owns the datapath
// G1    | requester 1 owns the datapath
module datapath_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    datapath_arbiter_if.slave bus
);
    import datapath_pkg::*;

    arb_state_e state;
    arb_state_e idle_pick;
    arb_state_e other_state;
    logic [1:0] gnt;
    logic       busy;
    logic       owner;
    logic       own_req;
    logic       own_last;
    logic       other_req;
    logic       drop;
    logic       done;
    logic       forced;
    logic       grant_end;
    logic       expired;
    logic [1:0] ovf_err_q;
    logic [1:0] abort_q;
    logic       timeout_err_q;
    logic [2:0] op_mux;
    logic [3:0] src1_mux;
    logic [3:0] src2_mux;
    logic [3:0] dest_mux;
`ifndef FIXED_PRIORITY_EN
    logic       ptr;
`endif

    assign gnt[REQ0]   = (state == G0);
    assign gnt[REQ1]   = (state == G1);
    assign busy        = (state != IDLE);
    assign owner       = (state == G1);
    assign own_req     = bus.req[owner];
    assign own_last    = bus.last[owner];
    assign other_req   = bus.req[~owner];
    assign other_state = owner ? G0 : G1;

    // An early drop wins over a coincident timeout; a last wins over the watchdog.
    assign drop      = busy & ~own_req;
    assign done      = busy & own_req & own_last;
    assign forced    = busy & own_req & ~own_last & expired;
    assign grant_end = drop | done | forced;

    always_comb begin
        idle_pick = IDLE;
`ifdef FIXED_PRIORITY_EN
        if (bus.req[REQ0]) begin
            idle_pick = G0;
        end else if (bus.req[REQ1]) begin
            idle_pick = G1;
        end
`else
        if (bus.req == 2'b11) begin
            idle_pick = ptr ? G1 : G0;
        end else if (bus.req[REQ0]) begin
            idle_pick = G0;
        end else if (bus.req[REQ1]) begin
            idle_pick = G1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ovf_err_q     <= '0;
            abort_q       <= '0;
            timeout_err_q <= 1'b0;
`ifndef FIXED_PRIORITY_EN
            ptr           <= 1'b0;
`endif
        end else begin
            ovf_err_q     <= {2{bus.overflow}} & gnt;
            abort_q       <= {2{drop}} & gnt;
            timeout_err_q <= forced;
            case (state)
                IDLE: state <= idle_pick;
                G0, G1: begin
                    if (grant_end) begin
                        state <= other_req ? other_state : IDLE;
`ifndef FIXED_PRIORITY_EN
                        ptr   <= ~owner;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    grant_timer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_grant_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (~busy | grant_end),
        .en     (busy),
        .expired(expired)
    );

    // The owner's fields reach the datapath only while it still holds req.
    always_comb begin
        op_mux   = OP_NOP;
        src1_mux = '0;
        src2_mux = '0;
        dest_mux = '0;
        if (busy && own_req) begin
            if (owner) begin
                op_mux   = bus.op1;
                src1_mux = bus.src1_1;
                src2_mux = bus.src2_1;
                dest_mux = bus.dest1;
            end else begin
                op_mux   = bus.op0;
                src1_mux = bus.src1_0;
                src2_mux = bus.src2_0;
                dest_mux = bus.dest0;
            end
        end
    end

    assign bus.gnt         = gnt;
    assign bus.busy        = busy;
    assign bus.op          = op_mux;
    assign bus.src1        = src1_mux;
    assign bus.src2        = src2_mux;
    assign bus.dest        = dest_mux;
    assign bus.ovf_err     = ovf_err_q;
    assign bus.abort       = abort_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: per-cycle comparison against a grant-ownership model plus literal pins.
module tb_datapath_arbiter;

    localparam int TIMEOUT = 16;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   vec_id;

    datapath_arbiter_if bus ();

    datapath_arbiter #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the datapath, how many cycles it has held it, whom contention favours.
    int         m_owner;
    int         m_age;
    int         m_ptr;
    logic [1:0] m_ovf;
    logic [1:0] m_abort;
    logic       m_tmo;
    bit         m_valid;

    initial begin
        m_owner = -1;
        m_age   = 0;
        m_ptr   = 0;
        m_ovf   = '0;
        m_abort = '0;
        m_tmo   = 1'b0;
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_age   = 0;
            m_ptr   = 0;
            m_ovf   = '0;
            m_abort = '0;
            m_tmo   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_ovf   = '0;
            m_abort = '0;
            m_tmo   = 1'b0;
            if (m_owner >= 0) begin
                bit ended;
                int other;
                other = 1 - m_owner;
                ended = 1'b0;
                if (bus.overflow) m_ovf[m_owner] = 1'b1;
                if (!bus.req[m_owner]) begin
                    m_abort[m_owner] = 1'b1;
                    ended = 1'b1;
                end else if (bus.last[m_owner]) begin
                    ended = 1'b1;
                end else if (m_age + 1 == TIMEOUT) begin
                    m_tmo = 1'b1;
                    ended = 1'b1;
                end
                m_age++;
                if (ended) begin
                    m_ptr   = other;
                    m_owner = bus.req[other] ? other : -1;
                    m_age   = 0;
                end
            end else if (bus.req != 2'b00) begin
`ifdef FIXED_PRIORITY_EN
                m_owner = bus.req[0] ? 0 : 1;
`else
                if (bus.req == 2'b11) m_owner = m_ptr;
                else                  m_owner = bus.req[0] ? 0 : 1;
`endif
                m_age = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int e_gnt;
            int e_op;
            int e_s1;
            int e_s2;
            int e_d;
            e_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
            e_op = 0; e_s1 = 0; e_s2 = 0; e_d = 0;
            if (m_owner == 0 && bus.req[0]) begin
                e_op = int'(bus.op0); e_s1 = int'(bus.src1_0); e_s2 = int'(bus.src2_0); e_d = int'(bus.dest0);
            end else if (m_owner == 1 && bus.req[1]) begin
                e_op = int'(bus.op1); e_s1 = int'(bus.src1_1); e_s2 = int'(bus.src2_1); e_d = int'(bus.dest1);
            end
            chk("gnt",         int'(bus.gnt),         e_gnt);
            chk("busy",        int'(bus.busy),        (m_owner >= 0) ? 1 : 0);
            chk("op",          int'(bus.op),          e_op);
            chk("src1",        int'(bus.src1),        e_s1);
            chk("src2",        int'(bus.src2),        e_s2);
            chk("dest",        int'(bus.dest),        e_d);
            chk("ovf_err",     int'(bus.ovf_err),     int'(m_ovf));
            chk("abort",       int'(bus.abort),       int'(m_abort));
            chk("timeout_err", int'(bus.timeout_err), int'(m_tmo));
        end
    end

    task automatic set_in(input logic [1:0] r, input logic [1:0] l, input logic ov);
        vec_id++;
        bus.req      = r;
        bus.last     = l;
        bus.overflow = ov;
        bus.op0      = 3'((vec_id % 6) + 1);
        bus.src1_0   = 4'(vec_id);
        bus.src2_0   = 4'(vec_id + 3);
        bus.dest0    = 4'(vec_id + 7);
        bus.op1      = 3'(((vec_id + 3) % 6) + 1);
        bus.src1_1   = 4'(15 - (vec_id % 16));
        bus.src2_1   = 4'(vec_id + 5);
        bus.dest1    = 4'(vec_id + 11);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [1:0] r, input logic [1:0] l, input logic ov, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(r, l, ov);
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2'b00, 2'b00, 1'b0, 2);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        vec_id      = 0;
        rst         = 1'b1;
        set_in(2'b00, 2'b00, 1'b0);
        tick();
        do_reset();
        chk("reset_gnt",  int'(bus.gnt),  0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_op",   int'(bus.op),   0);

        // single burst: one request cycle in IDLE, four granted cycles, last on the fourth
        cyc(2'b01, 2'b00, 1'b0, 1);
        chk("burst_gnt", int'(bus.gnt), 1);
        cyc(2'b01, 2'b00, 1'b0, 3);
        cyc(2'b01, 2'b01, 1'b0, 1);
        chk("burst_end_gnt", int'(bus.gnt), 0);
        cyc(2'b00, 2'b00, 1'b0, 2);

        // contention after reset: requester 0 first, then handoff without bubble
        do_reset();
        cyc(2'b11, 2'b00, 1'b0, 1);
        chk("cont_first_gnt", int'(bus.gnt), 1);
        cyc(2'b11, 2'b00, 1'b0, 2);
        cyc(2'b11, 2'b01, 1'b0, 1);
        chk("handoff_gnt", int'(bus.gnt), 2);

        // overflow on second G1 cycle
        cyc(2'b10, 2'b00, 1'b0, 1);
        cyc(2'b10, 2'b00, 1'b1, 1);
        chk("ovf_pulse", int'(bus.ovf_err), 2);
        chk("ovf_gnt_held", int'(bus.gnt), 2);
        cyc(2'b10, 2'b00, 1'b0, 1);
        chk("ovf_one_cycle", int'(bus.ovf_err), 0);

        // early drop of requester 1
        cyc(2'b10, 2'b00, 1'b0, 1);
        set_in(2'b00, 2'b00, 1'b0);
        #2;
        chk("drop_nop", int'(bus.op), 0);
        tick();
        chk("drop_abort", int'(bus.abort), 2);
        chk("drop_idle", int'(bus.gnt), 0);

        // round robin: after requester 0 is served, contention favours requester 1
        cyc(2'b11, 2'b00, 1'b0, 1);
        chk("rr_g0", int'(bus.gnt), 1);
        cyc(2'b01, 2'b01, 1'b0, 1);
        chk("rr_idle", int'(bus.gnt), 0);
        cyc(2'b11, 2'b00, 1'b0, 1);
`ifndef FIXED_PRIORITY_EN
        chk("rr_g1", int'(bus.gnt), 2);
`else
        chk("fixed_g0", int'(bus.gnt), 1);
`endif
        cyc(2'b00, 2'b00, 1'b0, 1);
        cyc(2'b00, 2'b00, 1'b0, 1);

        // overflow together with last still reports
        cyc(2'b10, 2'b00, 1'b0, 1);
        chk("ovl_gnt", int'(bus.gnt), 2);
        cyc(2'b10, 2'b10, 1'b1, 1);
        chk("ovl_ovf", int'(bus.ovf_err), 2);
        chk("ovl_abort", int'(bus.abort), 0);
        chk("ovl_idle", int'(bus.gnt), 0);

        // watchdog: requester 0 never signals last, requester 1 waits
        cyc(2'b01, 2'b00, 1'b0, 1);
        n = 0;
        while (bus.gnt[0] && n < 40) begin
            cyc(2'b11, 2'b00, 1'b0, 1);
            n++;
        end
        chk("wd_cycles", n, 16);
        chk("wd_pulse", int'(bus.timeout_err), 1);
        chk("wd_next_gnt", int'(bus.gnt), 2);
        cyc(2'b11, 2'b00, 1'b0, 1);
        chk("wd_one_cycle", int'(bus.timeout_err), 0);

        // reset mid-burst during G1
        cyc(2'b11, 2'b00, 1'b0, 1);
        rst = 1'b1;
        cyc(2'b11, 2'b00, 1'b1, 1);
        rst = 1'b0;
        chk("rst_gnt",  int'(bus.gnt),     0);
        chk("rst_busy", int'(bus.busy),    0);
        chk("rst_op",   int'(bus.op),      0);
        chk("rst_ovf",  int'(bus.ovf_err), 0);
        cyc(2'b11, 2'b00, 1'b0, 1);
        chk("rst_ptr", int'(bus.gnt), 1);
        cyc(2'b01, 2'b01, 1'b0, 1);
        cyc(2'b00, 2'b00, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
